udp_rx: RTL and testbench
=========================

UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 SHALL have parameter: BOARD_MAC, 48'h00_11_22_33_44_55, local MAC accepted as destination (broadcast FF:FF:FF:FF:FF:FF also accepted).
REQ-002 SHALL have parameter: BOARD_IP, 192.168.1.10, local IPv4 accepted as destination.
REQ-003 SHALL have port: gmii_rx_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: gmii_rx_dv  input  1  GMII receive data valid.
REQ-006 SHALL have port: gmii_rxd  input  8  GMII receive byte.
REQ-007 SHALL have port: rec_en  output  1  one-cycle strobe, rec_data valid.
REQ-008 SHALL have port: rec_data  output  32  payload word, first byte in [31:24].
REQ-009 SHALL have port: rec_pkt_done  output  1  one-cycle pulse, packet fully received.
REQ-010 SHALL have port: rec_byte_num  output  16  payload byte count of current/last packet.

Function
REQ-011 SHALL implement states IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END; a byte is consumed only when gmii_rx_dv=1.
REQ-012 IDLE -> PREAMBLE on first dv=1 with rxd=0x55; PREAMBLE requires six further 0x55 then 0xD5 -> ETH_HEAD; any other byte -> RX_END.
REQ-013 ETH_HEAD consumes 14 bytes; destination MAC SHALL equal BOARD_MAC or broadcast, EtherType SHALL equal 0x0800; else -> RX_END at the offending byte or header end.
REQ-014 IP_HEAD SHALL take header length from IHL (low nibble of byte 0) x4, minimum 20; protocol byte 9 SHALL be 17; bytes 16-19 SHALL equal BOARD_IP; else -> RX_END.
REQ-015 UDP_HEAD consumes 8 bytes; bytes 4-5 = UDP length L (big-endian); payload count SHALL be L-8, latched into rec_byte_num on the last UDP header byte; L<8 -> RX_END.
REQ-016 RX_DATA SHALL pack bytes big-endian; rec_en SHALL pulse the cycle after every 4th payload byte and after the final byte.
REQ-017 A final partial word SHALL carry valid bytes in the upper lanes and zeros in unused lower lanes.
REQ-018 rec_pkt_done SHALL pulse exactly one cycle, coincident with the final rec_en; state -> RX_END.
REQ-019 Zero payload (L=8): rec_pkt_done SHALL pulse the cycle after the last UDP header byte with rec_byte_num=0 and no rec_en.
REQ-020 RX_END SHALL discard bytes (trailing padding, FCS) until dv=0, then -> IDLE; FCS is not checked.
REQ-021 dv=0 in any state other than IDLE/RX_END SHALL abort to IDLE without rec_pkt_done; words already strobed stand.
REQ-022 Byte counters SHALL be 16-bit; wrap is impossible since L is 16-bit and counter resets per header/payload.
REQ-023 rec_data SHALL hold its value between strobes; rec_byte_num SHALL hold until next UDP header latch.
REQ-024 dv gaps (dv=0) SHALL NOT be tolerated within a frame (treated per REQ-021).

Reset
REQ-025 With rst_n=0 at a clock edge: state=IDLE, all counters 0, rec_en=0, rec_pkt_done=0, rec_data=0, rec_byte_num=0.
REQ-026 Reset asserted mid-packet SHALL abort immediately; after release the rest of that frame SHALL be ignored (frame start requires IDLE with 0x55).

Structure
REQ-027 Shared package udp_pkg SHALL hold ETH_TYPE_IP=16'h0800, IP_PROTO_UDP=8'd17, PREAMBLE byte constants, header lengths (14, 20, 8), and the state enum.
REQ-028 Single module, no sub-module; same udp_pkg used by the transmit side.

Verification
REQ-029 Valid frame, MAC=BOARD_MAC, IP=BOARD_IP, L=16, payload 01..08 -> rec_en twice: 0x01020304, 0x05060708; rec_pkt_done with second; rec_byte_num=8.
REQ-030 Broadcast MAC, payload AA BB CC DD EE (L=13) -> words 0xAABBCCDD, 0xEE000000; rec_byte_num=5.
REQ-031 Destination IP 192.168.1.11 or protocol 6 -> no rec_en, no rec_pkt_done; next valid frame received normally.
REQ-032 L=8 -> rec_pkt_done pulse, rec_byte_num=0, no rec_en.
REQ-033 dv dropped after 2 of 8 payload bytes -> no rec_en for that frame, no rec_pkt_done; return to IDLE.
REQ-034 rst_n=0 for one cycle during payload -> outputs 0, remainder ignored, following frame received correctly.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared UDP/IPv4/Ethernet constants, receive FSM state type and header byte helpers.
// Used by both the receive and transmit paths.
package udp_pkg;

    localparam logic [15:0] ETH_TYPE_IP     = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [15:0] PREAMBLE_REPEAT = 16'd6;
    localparam logic [15:0] ETH_HEAD_LEN    = 16'd14;
    localparam logic [15:0] IP_HEAD_MIN     = 16'd20;
    localparam logic [15:0] UDP_HEAD_LEN    = 16'd8;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HEAD,
        IP_HEAD,
        UDP_HEAD,
        RX_DATA,
        RX_END
    } rx_state_t;

    // Byte idx of a MAC address in wire order (byte 0 is the most significant).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [15:0] idx);
        case (idx)
            16'd0:   mac_byte = mac[47:40];
            16'd1:   mac_byte = mac[39:32];
            16'd2:   mac_byte = mac[31:24];
            16'd3:   mac_byte = mac[23:16];
            16'd4:   mac_byte = mac[15:8];
            16'd5:   mac_byte = mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        case (idx)
            2'd0:    ip_byte = ip[31:24];
            2'd1:    ip_byte = ip[23:16];
            2'd2:    ip_byte = ip[15:8];
            default: ip_byte = ip[7:0];
        endcase
    endfunction

endpackage

// File: rtl/udp_rx.sv
// GMII UDP receiver: filters on MAC/EtherType/IP/protocol and emits the payload
// as big-endian 32-bit words with a packet-done pulse on the final word.
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] rec_byte_num
);

    rx_state_t   r_state, w_next_state;
    logic [15:0] r_cnt;
    logic [15:0] r_ip_len;
    logic [15:0] r_udp_len;
    logic [15:0] r_byte_num;
    logic        r_mac_local, r_mac_bcast;
    logic [31:0] r_word, r_rec_data;
    logic        r_rec_en, r_pkt_done;

    logic        w_strobe, w_done, w_latch_len;
    logic        w_mac_local, w_mac_bcast, w_last_pay;
    logic [15:0] w_ihl_len;
    logic [1:0]  w_lane;
    logic [4:0]  w_shift;
    logic [31:0] w_word;

    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_strobe     = 1'b0;
        w_done       = 1'b0;
        w_latch_len  = 1'b0;
        // Running match over the six destination bytes; byte 0 restarts the match.
        w_mac_local  = (r_cnt == 16'd0 || r_mac_local) && (gmii_rxd == mac_byte(BOARD_MAC, r_cnt));
        w_mac_bcast  = (r_cnt == 16'd0 || r_mac_bcast) && (gmii_rxd == 8'hFF);
        w_ihl_len    = {10'd0, gmii_rxd[3:0], 2'b00};
        w_lane       = r_cnt[1:0];
        w_shift      = {2'd3 - w_lane, 3'b000};
        w_word       = (w_lane == 2'd0) ? {gmii_rxd, 24'd0} : (r_word | ({24'd0, gmii_rxd} << w_shift));
        w_last_pay   = (r_cnt == r_byte_num - 16'd1);

        case (r_state)
            IDLE: begin
                if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) w_next_state = PREAMBLE;
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) w_next_state = IDLE;
                else if (r_cnt < PREAMBLE_REPEAT) begin
                    if (gmii_rxd != PREAMBLE_BYTE) w_next_state = RX_END;
                end
                else w_next_state = (gmii_rxd == SFD_BYTE) ? ETH_HEAD : RX_END;
            end
            ETH_HEAD: begin
                if (!gmii_rx_dv) w_next_state = IDLE;
                else if (r_cnt < 16'd6) begin
                    if (!w_mac_local && !w_mac_bcast) w_next_state = RX_END;
                end
                else if (r_cnt == ETH_HEAD_LEN - 16'd2 && gmii_rxd != ETH_TYPE_IP[15:8])
                    w_next_state = RX_END;
                else if (r_cnt == ETH_HEAD_LEN - 16'd1)
                    w_next_state = (gmii_rxd == ETH_TYPE_IP[7:0]) ? IP_HEAD : RX_END;
            end
            IP_HEAD: begin
                if (!gmii_rx_dv) w_next_state = IDLE;
                else if (r_cnt == 16'd0) begin
                    if (w_ihl_len < IP_HEAD_MIN) w_next_state = RX_END;
                end
                else if (r_cnt == 16'd9 && gmii_rxd != IP_PROTO_UDP)
                    w_next_state = RX_END;
                else if (r_cnt >= 16'd16 && r_cnt <= 16'd19 && gmii_rxd != ip_byte(BOARD_IP, r_cnt[1:0]))
                    w_next_state = RX_END;
                else if (r_cnt == r_ip_len - 16'd1)
                    w_next_state = UDP_HEAD;
            end
            UDP_HEAD: begin
                if (!gmii_rx_dv) w_next_state = IDLE;
                else if (r_cnt == UDP_HEAD_LEN - 16'd1) begin
                    if (r_udp_len < UDP_HEAD_LEN) w_next_state = RX_END;
                    else begin
                        w_latch_len = 1'b1;
                        if (r_udp_len == UDP_HEAD_LEN) begin
                            w_done       = 1'b1;
                            w_next_state = RX_END;
                        end
                        else w_next_state = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (!gmii_rx_dv) w_next_state = IDLE;
                else begin
                    if (w_lane == 2'd3 || w_last_pay) w_strobe = 1'b1;
                    if (w_last_pay) begin
                        w_done       = 1'b1;
                        w_next_state = RX_END;
                    end
                end
            end
            RX_END: begin
                if (!gmii_rx_dv) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) begin
            r_cnt       <= 16'd0;
            r_ip_len    <= 16'd0;
            r_udp_len   <= 16'd0;
            r_byte_num  <= 16'd0;
            r_mac_local <= 1'b0;
            r_mac_bcast <= 1'b0;
            r_word      <= 32'd0;
            r_rec_data  <= 32'd0;
            r_rec_en    <= 1'b0;
            r_pkt_done  <= 1'b0;
        end
        else begin
            r_rec_en   <= w_strobe;
            r_pkt_done <= w_done;
            // Each header/payload section counts its own bytes from zero.
            if (w_next_state != r_state) r_cnt <= 16'd0;
            else if (gmii_rx_dv)         r_cnt <= r_cnt + 16'd1;
            if (gmii_rx_dv && r_state == ETH_HEAD && r_cnt < 16'd6) begin
                r_mac_local <= w_mac_local;
                r_mac_bcast <= w_mac_bcast;
            end
            if (gmii_rx_dv && r_state == IP_HEAD && r_cnt == 16'd0) r_ip_len <= w_ihl_len;
            if (gmii_rx_dv && r_state == UDP_HEAD && r_cnt == 16'd4) r_udp_len[15:8] <= gmii_rxd;
            if (gmii_rx_dv && r_state == UDP_HEAD && r_cnt == 16'd5) r_udp_len[7:0]  <= gmii_rxd;
            if (w_latch_len) r_byte_num <= r_udp_len - UDP_HEAD_LEN;
            if (gmii_rx_dv && r_state == RX_DATA) r_word <= w_word;
            if (w_strobe) r_rec_data <= w_word;
        end
    end

    assign rec_en       = r_rec_en;
    assign rec_data     = r_rec_data;
    assign rec_pkt_done = r_pkt_done;
    assign rec_byte_num = r_byte_num;

endmodule

// File: tb/tb_udp_rx.sv
// Self-checking bench for udp_rx: directed and randomized frames against a
// frame-level reference model with an expected-word scoreboard.
module tb_udp_rx;

    localparam logic [47:0] MY_MAC   = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BC_MAC   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] BAD_MAC  = 48'h00_11_22_33_44_56;
    localparam logic [31:0] MY_IP    = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [31:0] BAD_IP   = {8'd192, 8'd168, 8'd1, 8'd11};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv;
    logic [7:0]  rxd;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [15:0] exp_done_q[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  pay_q[$];
    int          pay_start;
    logic [15:0] mdl_byte_num = 16'd0;
    logic [31:0] mdl_last_word = 32'd0;

    udp_rx dut (
        .gmii_rx_clk (clk),
        .rst_n       (rst_n),
        .gmii_rx_dv  (dv),
        .gmii_rxd    (rxd),
        .rec_en      (rec_en),
        .rec_data    (rec_data),
        .rec_pkt_done(rec_pkt_done),
        .rec_byte_num(rec_byte_num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every strobe and done pulse must match the model's queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rec_en === 1'b1) begin
            check("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("word", rec_data, exp_q.pop_front());
        end
        if (rst_n === 1'b1 && rec_pkt_done === 1'b1) begin
            check("done_expected", 32'(exp_done_q.size() > 0), 32'd1);
            if (exp_done_q.size() > 0) begin
                logic [15:0] e;
                e = exp_done_q.pop_front();
                check("done_byte_num", 32'(rec_byte_num), 32'(e));
                check("done_with_en", 32'(rec_en), 32'(e != 16'd0));
            end
        end
    end

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [3:0] ihl,
                               input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] ulen,
                               input int npad);
        frame_q.delete();
        for (int i = 0; i < 7; i++) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frame_q.push_back(dst[i*8 +: 8]);
        for (int i = 0; i < 6; i++) frame_q.push_back(8'(8'h02 + i));
        frame_q.push_back(etype[15:8]);
        frame_q.push_back(etype[7:0]);
        frame_q.push_back({4'h4, ihl});
        for (int j = 1; j < 4 * int'(ihl); j++) begin
            if (j == 8)                 frame_q.push_back(8'd64);
            else if (j == 9)            frame_q.push_back(proto);
            else if (j >= 16 && j < 20) frame_q.push_back(dip[(19 - j)*8 +: 8]);
            else                        frame_q.push_back(8'(j * 7));
        end
        frame_q.push_back(8'h13); frame_q.push_back(8'h88);
        frame_q.push_back(8'h17); frame_q.push_back(8'h70);
        frame_q.push_back(ulen[15:8]); frame_q.push_back(ulen[7:0]);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        pay_start = frame_q.size();
        foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
        for (int i = 0; i < npad; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Frame-level reference: accept/reject from header fields, then chop the
    // delivered payload bytes into big-endian words.
    task automatic expect_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [3:0] ihl,
                                input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] ulen,
                                input int delivered, input bit reset_hit);
        bit ok;
        int plen;
        ok = (dst == MY_MAC || dst == BC_MAC) && etype == 16'h0800 && ihl >= 4'd5 &&
             proto == 8'd17 && dip == MY_IP && ulen >= 16'd8;
        if (!ok) return;
        plen = int'(ulen) - 8;
        mdl_byte_num = 16'(plen);
        for (int k = 0; k < plen; k += 4) begin
            int last;
            logic [31:0] w;
            last = (k + 4 < plen) ? k + 4 : plen;
            if (last <= delivered) begin
                w = 32'd0;
                for (int b = k; b < last; b++) w[(3 - (b - k))*8 +: 8] = pay_q[b];
                exp_q.push_back(w);
                mdl_last_word = w;
            end
        end
        if (delivered >= plen && !reset_hit) exp_done_q.push_back(16'(plen));
    endtask

    task automatic send_frame(input int drop_at, input int rst_at);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == drop_at) break;
            @(negedge clk);
            if (i == rst_at + 1) begin
                check("rst_rec_en", 32'(rec_en), 32'd0);
                check("rst_rec_data", rec_data, 32'd0);
                check("rst_byte_num", 32'(rec_byte_num), 32'd0);
                check("rst_pkt_done", 32'(rec_pkt_done), 32'd0);
            end
            rst_n = (i == rst_at) ? 1'b0 : 1'b1;
            dv    = 1'b1;
            rxd   = frame_q[i];
        end
        @(negedge clk);
        rst_n = 1'b1;
        dv    = 1'b0;
        rxd   = 8'h00;
        repeat (10) @(negedge clk);
        check("byte_num_hold", 32'(rec_byte_num), 32'(mdl_byte_num));
        check("data_hold", rec_data, mdl_last_word);
        check("pending_words", 32'(exp_q.size()), 32'd0);
        check("pending_done", 32'(exp_done_q.size()), 32'd0);
        exp_q.delete();
        exp_done_q.delete();
    endtask

    task automatic run_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [3:0] ihl,
                             input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] ulen,
                             input int npad, input int drop_pay, input int rst_pay);
        int delivered;
        int drop_at;
        int rst_at;
        build_frame(dst, etype, ihl, proto, dip, ulen, npad);
        drop_at   = (drop_pay >= 0) ? pay_start + drop_pay : -1;
        rst_at    = (rst_pay >= 0) ? pay_start + rst_pay : -10;
        delivered = (drop_pay >= 0) ? drop_pay : (rst_pay >= 0) ? rst_pay : pay_q.size();
        expect_frame(dst, etype, ihl, proto, dip, ulen, delivered, rst_pay >= 0);
        if (rst_pay >= 0) begin
            mdl_byte_num  = 16'd0;
            mdl_last_word = 32'd0;
        end
        send_frame(drop_at, rst_at);
    endtask

    task automatic fill_payload(input int n, input logic [7:0] base, input bit rnd);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(i)));
    endtask

    initial begin
        rst_n = 1'b0;
        dv    = 1'b0;
        rxd   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_rec_en", 32'(rec_en), 32'd0);
        check("reset_rec_data", rec_data, 32'd0);
        check("reset_pkt_done", 32'(rec_pkt_done), 32'd0);
        check("reset_byte_num", 32'(rec_byte_num), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill_payload(8, 8'h01, 1'b0);
        run_frame(MY_MAC, 16'h0800, 4'd5, 8'd17, MY_IP, 16'd16, 4, -1, -1);
        check("basic_byte_num", 32'(rec_byte_num), 32'd8);
        check("basic_last_word", rec_data, 32'h05060708);

        pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_frame(BC_MAC, 16'h0800, 4'd5, 8'd17, MY_IP, 16'd13, 6, -1, -1);
        check("bcast_last_word", rec_data, 32'hEE000000);

        fill_payload(8, 8'h40, 1'b0);
        run_frame(MY_MAC, 16'h0800, 4'd5, 8'd17, BAD_IP, 16'd16, 4, -1, -1);
        run_frame(MY_MAC, 16'h0800, 4'd5, 8'd6, MY_IP, 16'd16, 4, -1, -1);
        fill_payload(6, 8'h60, 1'b0);
        run_frame(MY_MAC, 16'h0800, 4'd5, 8'd17, MY_IP, 16'd14, 4, -1, -1);

        fill_payload(0, 8'h00, 1'b0);
        run_frame(MY_MAC, 16'h0800, 4'd5, 8'd17, MY_IP, 16'd8, 8, -1, -1);
        check("zero_byte_num", 32'(rec_byte_num), 32'd0);

        fill_payload(8, 8'h80, 1'b0);
        run_frame(MY_MAC, 16'h0800, 4'd5, 8'd17, MY_IP, 16'd16, 4, 2, -1);

        fill_payload(8, 8'h90, 1'b0);
        run_frame(MY_MAC, 16'h0800, 4'd6, 8'd17, MY_IP, 16'd16, 4, -1, 6);
        fill_payload(7, 8'hA0, 1'b0);
        run_frame(MY_MAC, 16'h0800, 4'd5, 8'd17, MY_IP, 16'd15, 4, -1, -1);

        for (int n = 0; n < 30; n++) begin
            logic [47:0] dst;
            logic [15:0] etype, ulen;
            logic [3:0]  ihl;
            logic [7:0]  proto;
            logic [31:0] dip;
            int          plen, sel;
            sel   = $urandom_range(0, 5);
            dst   = (sel == 0) ? BAD_MAC : (sel == 1) ? BC_MAC : MY_MAC;
            etype = ($urandom_range(0, 7) == 0) ? 16'h86DD : 16'h0800;
            sel   = $urandom_range(0, 4);
            ihl   = (sel == 3) ? 4'd6 : (sel == 4) ? 4'd4 : 4'd5;
            proto = ($urandom_range(0, 5) == 0) ? 8'd6 : 8'd17;
            dip   = ($urandom_range(0, 5) == 0) ? BAD_IP : MY_IP;
            plen  = $urandom_range(0, 13);
            ulen  = 16'(plen + 8);
            if ($urandom_range(0, 9) == 0) begin
                plen = 0;
                ulen = 16'($urandom_range(0, 7));
            end
            fill_payload(plen, 8'h00, 1'b1);
            run_frame(dst, etype, ihl, proto, dip, ulen, 4 + $urandom_range(0, 3), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
